// File: rtl/sd_port_arbiter.sv
`timescale 1ns/1ps
// Arbitrates the single host SD port between the hard-disk controller (0) and floppy controller (1), round-robin on ties.
// Strobe and grant appear one cycle after a request is sampled; requests are held levels until done, with no other backpressure.

module sd_port_arbiter #(
  parameter int TMO_W = 20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  cl_buff_din0,
  input  logic [7:0]  cl_buff_din1,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [1:0]  grant,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic [1:0]  cl_buff_wr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_XFER, ST_DONE} state_t;

  // Compared before the increment: the timeout edge is the one that would bring the count to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic             last_owner;
  logic [TMO_W-1:0] tmo_cnt;

  logic [1:0]  pending;
  logic        win;
  logic        win_rd;
  logic        win_wr;
  logic [1:0]  win_oh;
  logic [31:0] win_lba;

  always_comb begin
    pending = req_rd | req_wr;
    win     = (pending == 2'b11) ? ~last_owner : pending[1];
    win_rd  = win ? req_rd[1] : req_rd[0];
    win_wr  = win ? req_wr[1] : req_wr[0];
    win_oh  = win ? 2'b10 : 2'b01;
    win_lba = win ? req_lba1 : req_lba0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      sd_lba     <= 32'h0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      done       <= 2'b00;
      err        <= 2'b00;
      last_owner <= 1'b1;
      tmo_cnt    <= '0;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (pending != 2'b00) begin
            last_owner <= win;
            tmo_cnt    <= '0;
            // Read and write together is meaningless: reject without touching the host port.
            if (win_rd && win_wr) begin
              done  <= win_oh;
              err   <= win_oh;
              state <= ST_DONE;
            end else begin
              grant  <= win_oh;
              sd_lba <= win_lba;
              sd_rd  <= win_rd;
              sd_wr  <= win_wr;
              state  <= ST_WAIT_ACK;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (sd_ack) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            tmo_cnt <= '0;
            state   <= ST_XFER;
          end else if (tmo_cnt == TMO_LAST) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            done    <= grant;
            err     <= grant;
            grant   <= 2'b00;
            tmo_cnt <= '0;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (!sd_ack) begin
            done  <= grant;
            grant <= 2'b00;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cl_buff_wr  = grant & {2{sd_buff_wr & sd_ack}};
  assign sd_buff_din = grant[0] ? cl_buff_din0 : (grant[1] ? cl_buff_din1 : 8'h00);

endmodule
